tri_fill_sequencer: RTL and testbench

- Upstream write-sequencing stage for the 16x8 register bank.
- Serialises the two triangular fill passes into a single write port, one write per cycle:
  - low pass: cc operand, columns 1..i;
  - high pass: bb operand, columns i..14.
- The bank therefore has exactly one driver.
- Also produces the registered cc&bb word consumed by the downstream stage.

---
 rtl/tri_fill_pkg.sv | 25 ++
 rtl/tri_fill_bank.sv | 54 +++++
 rtl/tri_fill_sequencer.sv | 174 +++++++++++++++++
 tb/tb_tri_fill_sequencer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/tri_fill_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tri_fill_pkg
//  Purpose  : Shared types and default sizing for the triangular fill
//             sequencer and its register bank.
//  Revision : 1.0 - initial release
// ============================================================================
package tri_fill_pkg;

  // Default sizing of the 16x8 bank and the outer row range
  localparam int DW_DEF      = 8;
  localparam int DEPTH_DEF   = 16;
  localparam int ROW_MAX_DEF = 7;
  localparam int ADDR_W      = $clog2(DEPTH_DEF);

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage : tri_fill_pkg
`default_nettype wire

// File: rtl/tri_fill_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tri_fill_bank
//  Purpose  : DEPTH x DW register file with one synchronous write port and
//             one registered read port (read-before-write); cleared on rst.
//  Revision : 1.0 - initial release
// ============================================================================
module tri_fill_bank
  import tri_fill_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [DW-1:0] rd_data_q;
  logic [DW-1:0] rd_data_d;

  // Next bank image and read data; read samples the pre-write contents
  always_comb begin
    mem_d     = mem_q;
    rd_data_d = mem_q[rd_addr];
    if (wr_en) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  // Bank storage and read register, synchronously cleared
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_q[k] <= '0;
      end
      rd_data_q <= '0;
    end else begin
      mem_q     <= mem_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule : tri_fill_bank
`default_nettype wire

// File: rtl/tri_fill_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tri_fill_sequencer
//  Purpose  : Serialises the low (cc, columns 1..i) and high (bb, columns
//             i..DEPTH-2) triangular fill passes into the single write port
//             of the register bank, one write per cycle, and registers cc&bb.
//  Revision : 1.0 - initial release
// ============================================================================
module tri_fill_sequencer
  import tri_fill_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int ROW_MAX = ROW_MAX_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [DW-1:0]            cc,
  input  logic [DW-1:0]            bb,
  output logic                     busy,
  output logic                     done,
  output logic                     wr_en,
  output logic [$clog2(DEPTH)-1:0] wr_addr,
  output logic [DW-1:0]            wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DW-1:0]            rd_data,
  output logic [DW-1:0]            dd
);

  localparam int AW = $clog2(DEPTH);

  // Counters are AW bits wide; rows beyond DEPTH-1 would wrap them
  if (ROW_MAX > DEPTH - 1 || ROW_MAX < 2 || DEPTH < 3) begin : g_param_check
    $error("tri_fill_sequencer: ROW_MAX must lie in 2..DEPTH-1");
  end

  localparam logic [AW-1:0] c_one    = AW'(1);
  localparam logic [AW-1:0] c_j_last = AW'(DEPTH - 2);
  localparam logic [AW-1:0] c_i_last = AW'(ROW_MAX - 1);

  state_t        state_q,   state_d;
  logic [AW-1:0] i_q,       i_d;
  logic [AW-1:0] j_q,       j_d;
  logic [DW-1:0] cc_q,      cc_d;
  logic [DW-1:0] bb_q,      bb_d;
  logic          busy_q,    busy_d;
  logic          done_q,    done_d;
  logic          wr_en_q,   wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;
  logic [DW-1:0] dd_q,      dd_d;

  // Next-state, counter and output-register decode for the fill sequence
  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    cc_d      = cc_q;
    bb_d      = bb_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    dd_d      = cc & bb;

    case (state_q)
      IDLE: begin
        if (start) begin
          cc_d    = cc;
          bb_d    = bb;
          i_d     = c_one;
          j_d     = c_one;
          state_d = LO;
        end
      end

      LO: begin
        busy_d    = 1'b1;
        wr_en_d   = 1'b1;
        wr_addr_d = j_q;
        wr_data_d = cc_q;
        if (j_q == i_q) begin
          // High pass of this row starts on the diagonal column
          j_d     = i_q;
          state_d = HI;
        end else begin
          j_d = j_q + c_one;
        end
      end

      HI: begin
        busy_d    = 1'b1;
        wr_en_d   = 1'b1;
        wr_addr_d = j_q;
        wr_data_d = bb_q;
        if (j_q == c_j_last) begin
          if (i_q == c_i_last) begin
            state_d = DONE;
          end else begin
            i_d     = i_q + c_one;
            j_d     = c_one;
            state_d = LO;
          end
        end else begin
          j_d = j_q + c_one;
        end
      end

      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state, counters, frozen operands and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      i_q       <= '0;
      j_q       <= '0;
      cc_q      <= '0;
      bb_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      dd_q      <= '0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      j_q       <= j_d;
      cc_q      <= cc_d;
      bb_q      <= bb_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      dd_q      <= dd_d;
    end
  end

  // The bank commits on the same edge that loads the write output registers
  tri_fill_bank #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_bank (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en_d),
    .wr_addr (wr_addr_d),
    .wr_data (wr_data_d),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign busy    = busy_q;
  assign done    = done_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign dd      = dd_q;

endmodule : tri_fill_sequencer
`default_nettype wire

// File: tb/tb_tri_fill_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tri_fill_sequencer
//  Purpose  : Directed self-checking bench for tri_fill_sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tri_fill_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] cc;
  logic [7:0] bb;
  logic       busy;
  logic       done;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic [7:0] dd;

  int checks = 0;
  int errors = 0;

  tri_fill_sequencer dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .cc      (cc),
    .bb      (bb),
    .busy    (busy),
    .done    (done),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .dd      (dd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write n (1-based) of a fill: row r, position p within its 15 writes
  function automatic logic [3:0] exp_addr(input int n);
    int p = (n - 1) % 15;
    int r = (n - 1) / 15 + 1;
    return (p < r) ? 4'(p + 1) : 4'(p);
  endfunction

  function automatic logic exp_is_lo(input int n);
    int p = (n - 1) % 15;
    int r = (n - 1) / 15 + 1;
    return (p < r);
  endfunction

  // Read every bank address; clr selects the all-zero image
  task automatic readback(input logic [7:0] c, input logic [7:0] b, input bit clr);
    logic [7:0] e;
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      @(posedge clk); #1;
      if (clr || a == 0 || a == 15) e = 8'h00;
      else if (a <= 5)              e = c;
      else                          e = b;
      chk($sformatf("readback[%0d]", a), rd_data, e);
    end
  endtask

  // One fill with optional mid-fill operand change, start re-pulse or reset
  task automatic run_fill(input logic [7:0] c, input logic [7:0] b,
                          input int chg_k, input logic [7:0] chg_cc,
                          input int st_k, input int rst_k, input bit rdw);
    int nwr = 0;
    int done_k = 0;
    int done_cnt = 0;
    bit wr_ok = 1'b1;
    if (rdw) rd_addr = 4'd6;
    cc = c; bb = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (wr_en) begin
        nwr++;
        if (wr_addr !== exp_addr(nwr) ||
            wr_data !== (exp_is_lo(nwr) ? c : b) || k != nwr) begin
          wr_ok = 1'b0;
          chk($sformatf("write%0d_addr", nwr), wr_addr, exp_addr(nwr));
          chk($sformatf("write%0d_data", nwr), wr_data, exp_is_lo(nwr) ? c : b);
        end
      end
      if (done) begin
        done_cnt++;
        done_k = k;
      end
      if (k == 1) begin
        chk("first_write_addr", wr_addr, 4'd1);
        chk("first_write_data", wr_data, c);
      end
      if (k == 2 && rst_k == 0) begin
        chk("second_write_addr", wr_addr, 4'd1);
        chk("second_write_data", wr_data, b);
      end
      if (k == 5) chk("busy_mid", busy, 1'b1);
      if (chg_k != 0 && k == chg_k) begin
        chk("dd_before_change", dd, c & b);
        cc = chg_cc;
      end
      if (chg_k != 0 && k == chg_k + 1) chk("dd_after_change", dd, chg_cc & b);
      if (st_k != 0 && k == st_k) begin
        start = 1'b1;
        cc = 8'h11;
      end
      if (st_k != 0 && k == st_k + 1) start = 1'b0;
      if (rdw && k == 81) begin
        chk("rdw_wr_addr", wr_addr, 4'd6);
        chk("rdw_old_value", rd_data, b);
      end
      if (rdw && k == 82) chk("rdw_new_value", rd_data, c);
      if (rdw && k == 83) chk("rdw_hi_value", rd_data, b);
      if (rst_k != 0 && k == rst_k) rst = 1'b1;
      if (rst_k != 0 && k == rst_k + 1) begin
        rst = 1'b0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_wr_en", wr_en, 1'b0);
        chk("abort_done", done, 1'b0);
      end
    end
    chk("write_sequence_ok", wr_ok, 1'b1);
    if (rst_k == 0) begin
      chk("write_count", nwr, 90);
      chk("done_cycle", done_k, 91);
      chk("done_pulses", done_cnt, 1);
    end else begin
      chk("abort_write_count", nwr, rst_k);
      chk("abort_no_done", done_cnt, 0);
    end
    chk("idle_busy", busy, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; cc = 8'hFF; bb = 8'hFF; rd_addr = 4'd0;

    // Reset dominates start and clears everything, including dd
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_dd", dd, 8'h00);
    chk("reset_wr_en", wr_en, 1'b0);
    start = 1'b0; rst = 1'b0; cc = 8'h00; bb = 8'h00;
    @(posedge clk); #1;
    chk("idle_busy_after_reset", busy, 1'b0);
    readback(8'h00, 8'h00, 1'b1);

    // Basic fill with read-during-write at address 6 in row 6
    run_fill(8'hA5, 8'h3C, 0, 8'h00, 0, 0, 1'b1);
    readback(8'hA5, 8'h3C, 1'b0);

    // Operands frozen at start while dd follows the inputs
    run_fill(8'hFF, 8'h0F, 30, 8'h00, 0, 0, 1'b0);
    readback(8'hFF, 8'h0F, 1'b0);

    // A start pulse during the fill is ignored
    run_fill(8'h66, 8'h99, 0, 8'h00, 20, 0, 1'b0);
    readback(8'h66, 8'h99, 1'b0);

    // Reset at write 40 aborts the fill and clears the bank
    run_fill(8'h5A, 8'hC3, 0, 8'h00, 0, 40, 1'b0);
    readback(8'h00, 8'h00, 1'b1);

    // A fresh fill after the abort completes normally
    run_fill(8'h81, 8'h7E, 0, 8'h00, 0, 0, 1'b0);
    readback(8'h81, 8'h7E, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_tri_fill_sequencer
`default_nettype wire
